// File: rtl/fwft_fifo_8to32.sv
// First-word-fall-through FIFO: byte writes packed into RD_WIDTH-bit read words.
// Define FIFO_ERR_FLAGS_EN to add the o_overflow / o_underflow pulse outputs.
module fwft_fifo_8to32 #(
    parameter int WR_DEPTH       = 4096,
    parameter int WR_DEPTH_AFULL = 2048,
    parameter int RD_WIDTH       = 32,
    parameter int WORD_SWAP      = 1
) (
    input  logic                i_sys_clk,
    input  logic                i_sys_srst_n,
    input  logic                i_wren,
    input  logic [7:0]          i_wdata,
    output logic                o_full,
    output logic                o_afull,
    input  logic                i_rden,
    output logic [RD_WIDTH-1:0] o_rdata,
    output logic                o_rdata_vld,
    output logic [31:0]         o_fillcount
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                o_overflow,
    output logic                o_underflow
`endif
);

    localparam int BPW   = RD_WIDTH / 8;
    localparam int DEPTH = WR_DEPTH / BPW;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = (BPW > 1) ? $clog2(BPW) : 1;

    logic [RD_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic [CW-1:0]       byte_cnt;
    logic [RD_WIDTH-1:0] pack;
    logic [RD_WIDTH-1:0] pack_next;
    logic [31:0]         fill;
    logic                accept;
    logic                word_done;
    logic                pop;
    logic                mem_empty;
    logic                load;
    int                  lane;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        accept    = i_wren && !o_full;
        pop       = i_rden && o_rdata_vld;
        word_done = accept && (byte_cnt == CW'(BPW - 1));
        mem_empty = (wr_ptr == rd_ptr);
        // The head register refills whenever it is empty or being popped this edge.
        load      = !mem_empty && (!o_rdata_vld || pop);
        lane      = (WORD_SWAP != 0) ? (BPW - 1 - int'(byte_cnt)) : int'(byte_cnt);
        pack_next = pack;
        pack_next[lane*8 +: 8] = i_wdata;
    end

    // NOTE: storage has no reset; pointers define which entries are meaningful.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_srst_n && word_done) begin
            mem[wr_ptr[AW-1:0]] <= pack_next;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_srst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            byte_cnt    <= '0;
            pack        <= '0;
            fill        <= '0;
            o_rdata     <= '0;
            o_rdata_vld <= 1'b0;
        end else begin
            if (accept) begin
                pack     <= pack_next;
                byte_cnt <= word_done ? '0 : byte_cnt + CW'(1);
            end
            if (word_done) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (load) begin
                o_rdata     <= mem[rd_ptr[AW-1:0]];
                rd_ptr      <= rd_ptr + (AW+1)'(1);
                o_rdata_vld <= 1'b1;
            end else if (pop) begin
                o_rdata_vld <= 1'b0;
            end
            fill <= fill + 32'(accept) - (pop ? 32'(BPW) : 32'd0);
        end
    end

    assign o_fillcount = fill;
    assign o_full      = (fill == 32'(WR_DEPTH));
    assign o_afull     = (fill >= 32'(WR_DEPTH_AFULL));

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_srst_n) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= i_wren && o_full;
            o_underflow <= i_rden && !o_rdata_vld;
        end
    end
`endif

endmodule

// File: tb/tb_fwft_fifo_8to32.sv
// Directed bench for fwft_fifo_8to32: packing order, FWFT latency, full/afull, wrap, reset.
module tb_fwft_fifo_8to32;

    logic        clk;
    logic        srst_n;
    logic        wren;
    logic [7:0]  wdata;
    logic        rden;
    logic        full, afull, vld;
    logic [31:0] rdata, fillcount;
    logic        le_full, le_afull, le_vld;
    logic [31:0] le_rdata, le_fillcount;
`ifdef FIFO_ERR_FLAGS_EN
    logic        overflow, underflow, le_overflow, le_underflow;
`endif

    int checks   = 0;
    int failures = 0;

    fwft_fifo_8to32 #(.WR_DEPTH(4096), .WR_DEPTH_AFULL(2048), .RD_WIDTH(32), .WORD_SWAP(1)) u_dut (
        .i_sys_clk(clk), .i_sys_srst_n(srst_n), .i_wren(wren), .i_wdata(wdata),
        .o_full(full), .o_afull(afull), .i_rden(rden), .o_rdata(rdata),
        .o_rdata_vld(vld), .o_fillcount(fillcount)
`ifdef FIFO_ERR_FLAGS_EN
        , .o_overflow(overflow), .o_underflow(underflow)
`endif
    );

    fwft_fifo_8to32 #(.WR_DEPTH(4096), .WR_DEPTH_AFULL(2048), .RD_WIDTH(32), .WORD_SWAP(0)) u_dut_le (
        .i_sys_clk(clk), .i_sys_srst_n(srst_n), .i_wren(wren), .i_wdata(wdata),
        .o_full(le_full), .o_afull(le_afull), .i_rden(rden), .o_rdata(le_rdata),
        .o_rdata_vld(le_vld), .o_fillcount(le_fillcount)
`ifdef FIFO_ERR_FLAGS_EN
        , .o_overflow(le_overflow), .o_underflow(le_underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wren  = 1'b1;
        wdata = b;
        step();
        wren  = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7) ^ (i >> 5));
    endfunction

    function automatic logic [31:0] pat_word(input int j);
        return {pat(4*j), pat(4*j + 1), pat(4*j + 2), pat(4*j + 3)};
    endfunction

    initial begin
        logic [31:0] q[$];
        logic [31:0] acc;
        logic [7:0]  b;
        int          nb, errs, popped;

        srst_n = 1'b0; wren = 1'b0; rden = 1'b0; wdata = 8'h00;
        step();
        step();
        check("reset_full", full, 0);
        check("reset_afull", afull, 0);
        check("reset_vld", vld, 0);
        check("reset_fill", fillcount, 0);
        check("reset_rdata", rdata, 0);
        srst_n = 1'b1;

        // One word: both byte orders and one-edge FWFT latency.
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
        check("word_vld_latency", vld, 0);
        check("word_fill", fillcount, 4);
        step();
        check("word_vld", vld, 1);
        check("word_be", rdata, 32'h1122_3344);
        check("word_le", le_rdata, 32'h4433_2211);
        step();
        check("word_hold", rdata, 32'h1122_3344);
        rden = 1'b1;
        step();
        rden = 1'b0;
        check("word_pop_vld", vld, 0);
        check("word_pop_fill", fillcount, 0);

        // Partial word is never readable.
        write_byte(8'hA1); write_byte(8'hA2); write_byte(8'hA3);
        step();
        check("partial_vld", vld, 0);
        check("partial_fill", fillcount, 3);
        write_byte(8'hA4);
        step();
        check("partial_done_vld", vld, 1);
        check("partial_done_data", rdata, 32'hA1A2_A3A4);
        rden = 1'b1;
        step();
        rden = 1'b0;
        check("partial_pop_fill", fillcount, 0);
        check("partial_pop_vld", vld, 0);

        // Fill to capacity, check thresholds and a dropped write.
        for (int i = 0; i < 4096; i++) begin
            write_byte(pat(i));
            if (i + 1 == 2047) check("afull_2047", afull, 0);
            if (i + 1 == 2048) check("afull_2048", afull, 1);
            if (i + 1 == 4095) check("full_4095", full, 0);
        end
        check("full_fill", fillcount, 4096);
        check("full_flag", full, 1);
        write_byte(8'hEE);
        check("overflow_fill", fillcount, 4096);
        check("overflow_full", full, 1);
        check("overflow_head", rdata, pat_word(0));
`ifdef FIFO_ERR_FLAGS_EN
        check("overflow_flag", overflow, 1);
`endif

        // Drain at full rate: a valid, correct word must be present every cycle.
        errs = 0;
        rden = 1'b1;
        for (int j = 0; j < 1024; j++) begin
            if (!(vld === 1'b1 && rdata === pat_word(j))) errs++;
            step();
        end
        rden = 1'b0;
        check("drain_errors", errs, 0);
        check("drain_vld", vld, 0);
        check("drain_fill", fillcount, 0);
        check("drain_full", full, 0);
        check("drain_afull", afull, 0);

        // Continuous write + read through 2.5x the word depth.
        errs = 0; popped = 0; nb = 0; acc = '0;
        rden = 1'b1;
        wren = 1'b1;
        for (int c = 0; c < 10240; c++) begin
            b = 8'($urandom);
            wdata = b;
            if (vld) begin
                if (q.size() == 0 || rdata !== q[0]) errs++;
                if (q.size() != 0) void'(q.pop_front());
                popped++;
            end
            step();
            acc = {acc[23:0], b};
            nb++;
            if (nb == 4) begin
                q.push_back(acc);
                nb = 0;
            end
        end
        wren = 1'b0;
        for (int c = 0; c < 20 && (vld || q.size() != 0); c++) begin
            if (vld) begin
                if (q.size() == 0 || rdata !== q[0]) errs++;
                if (q.size() != 0) void'(q.pop_front());
                popped++;
            end
            step();
        end
        rden = 1'b0;
        check("stream_errors", errs, 0);
        check("stream_popped", popped, 2560);
        check("stream_fill", fillcount, 0);
        check("stream_vld", vld, 0);

        // Read of an empty FIFO is ignored.
        step();
        rden = 1'b1;
        step();
        rden = 1'b0;
        check("underrun_fill", fillcount, 0);
        check("underrun_vld", vld, 0);
`ifdef FIFO_ERR_FLAGS_EN
        check("underflow_pulse", underflow, 1);
        step();
        check("underflow_clear", underflow, 0);
`endif

        // Reset mid-stream with 2 words + 1 byte held, reset beating a concurrent write/read.
        for (int i = 0; i < 9; i++) write_byte(8'(8'h30 + i));
        step();
        check("pre_reset_fill", fillcount, 9);
        check("pre_reset_vld", vld, 1);
        srst_n = 1'b0; wren = 1'b1; wdata = 8'h55; rden = 1'b1;
        step();
        srst_n = 1'b1; wren = 1'b0; rden = 1'b0;
        check("mid_reset_vld", vld, 0);
        check("mid_reset_fill", fillcount, 0);
        check("mid_reset_full", full, 0);
        check("mid_reset_afull", afull, 0);
        check("mid_reset_rdata", rdata, 0);
        write_byte(8'hAA); write_byte(8'hBB); write_byte(8'hCC); write_byte(8'hDD);
        step();
        check("post_reset_vld", vld, 1);
        check("post_reset_data", rdata, 32'hAABB_CCDD);
        check("post_reset_fill", fillcount, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
